// File: rtl/knips_pkg.sv
// Shared types and constants for the fetch-side pipeline blocks.
package knips_pkg;

  localparam int unsigned IW_DEF  = 9;
  localparam int unsigned PCW_DEF = 16;

  localparam logic [IW_DEF-1:0] HALT_OP = 9'h1FF;

  typedef enum logic {S_FILL, S_HALTQ} fq_state_t;

  typedef struct packed {
    logic [PCW_DEF-1:0] pc;
    logic [IW_DEF-1:0]  instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue: one write port, one combinational read port.
module fetch_queue_mem #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 4
) (
  input  logic                     CLK,
  input  logic                     Init,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetch FIFO between fetch and decode; stalls fetch when full or once a HALT is queued.
module fetch_queue
  import knips_pkg::*;
#(
  parameter int unsigned IW    = IW_DEF,
  parameter int unsigned PCW   = PCW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Init,
  input  logic [PCW-1:0]           PC_in,
  input  logic [IW-1:0]            Instr_in,
  input  logic                     Fill,
  input  logic                     Flush,
  input  logic                     Deq,
  output logic [IW-1:0]            Out_instr,
  output logic [PCW-1:0]           Out_pc,
  output logic                     Out_valid,
  output logic                     Stall,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  fq_state_t     state_q, state_d;

  logic [PW-1:0]       count;
  logic                full;
  logic                do_enq;
  logic                do_deq;
  logic [PCW+IW-1:0]   rd_entry;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == PW'(DEPTH));
  assign do_enq = Fill & ~full & (state_q == S_FILL) & ~Flush;
  assign do_deq = Deq & (count != '0) & ~Flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    if (Flush) begin
      rd_ptr_d = wr_ptr_q;
      state_d  = S_FILL;
    end else begin
      if (do_enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (Instr_in == IW'(HALT_OP)) begin
          state_d = S_HALTQ;
        end
      end
      if (do_deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      state_q  <= S_FILL;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      state_q  <= state_d;
    end
  end

  fetch_queue_mem #(
    .Width (PCW + IW),
    .Depth (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .Init  (Init),
    .we    (do_enq),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({PC_in, Instr_in}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  assign {Out_pc, Out_instr} = rd_entry;
  assign Out_valid           = (count != '0);
  assign Stall               = full | (state_q == S_HALTQ);
  assign Count               = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table plus hand sequences, checked against a queue model.
module tb_fetch_queue;
  import knips_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Init;
  logic [15:0] PC_in;
  logic [8:0]  Instr_in;
  logic        Fill, Flush, Deq;
  logic [8:0]  Out_instr;
  logic [15:0] Out_pc;
  logic        Out_valid, Stall;
  logic [2:0]  Count;

  always #5 CLK = ~CLK;

  fetch_queue #(
    .IW    (9),
    .PCW   (16),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .Init      (Init),
    .PC_in     (PC_in),
    .Instr_in  (Instr_in),
    .Fill      (Fill),
    .Flush     (Flush),
    .Deq       (Deq),
    .Out_instr (Out_instr),
    .Out_pc    (Out_pc),
    .Out_valid (Out_valid),
    .Stall     (Stall),
    .Count     (Count)
  );

  int checks = 0;
  int errors = 0;

  fq_entry_t sb[$];
  bit        m_halt = 1'b0;

  typedef struct {
    logic        fill, deq, flush;
    logic [15:0] pc;
    int          exp_count;
    logic        exp_stall, exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare against the model before the edge, then advance the model.
  task automatic step(input logic f, input logic d, input logic fl,
                      input logic [15:0] pc, input logic [8:0] ins);
    bit        enq;
    fq_entry_t e;
    Fill = f; Deq = d; Flush = fl; PC_in = pc; Instr_in = ins;
    chk("pre_count", 32'(Count), sb.size());
    chk("pre_valid", 32'(Out_valid), 32'(sb.size() != 0));
    chk("pre_stall", 32'(Stall), 32'((sb.size() == DEPTH) || m_halt));
    if (fl) begin
      sb.delete();
      m_halt = 1'b0;
    end else begin
      enq = f && (sb.size() < DEPTH) && !m_halt;
      if (d && sb.size() != 0) begin
        chk("head_pc", 32'(Out_pc), 32'(sb[0].pc));
        chk("head_instr", 32'(Out_instr), 32'(sb[0].instr));
        void'(sb.pop_front());
      end
      if (enq) begin
        e.pc = pc;
        e.instr = ins;
        sb.push_back(e);
        if (ins == HALT_OP) m_halt = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    Fill = 1'b0; Deq = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    //          fill deq flush pc  count stall valid head_pc
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'd0, 1, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'd1, 2, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'd2, 3, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'd3, 4, 1'b1, 1'b1, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'd4, 4, 1'b1, 1'b1, 16'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'd5, 3, 1'b0, 1'b1, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'd0, 2, 1'b0, 1'b1, 16'd2};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 16'd6, 0, 1'b0, 1'b0, 16'd0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'd8, 1, 1'b0, 1'b1, 16'd8};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 16'd0, 0, 1'b0, 1'b0, 16'd0};

    Init = 1'b1; Fill = 1'b0; Deq = 1'b0; Flush = 1'b0; PC_in = '0; Instr_in = '0;
    #12;
    chk("rst_count", 32'(Count), 0);
    chk("rst_valid", 32'(Out_valid), 0);
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_pc", 32'(Out_pc), 0);
    chk("rst_instr", 32'(Out_instr), 0);
    Init = 1'b0;
    @(posedge CLK);
    #1;

    // Fill to full, refused fill, fill+deq while full, triple fill/deq/flush.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].fill, vecs[i].deq, vecs[i].flush, vecs[i].pc, 9'h040 + vecs[i].pc[8:0]);
      chk($sformatf("vec%0d_count", i), 32'(Count), vecs[i].exp_count);
      chk($sformatf("vec%0d_stall", i), 32'(Stall), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_valid", i), 32'(Out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_head", i), 32'(Out_pc), 32'(vecs[i].exp_pc));
    end

    // HALT queued: stall, refuse fills, drain to empty without leaving halt state.
    step(1'b1, 1'b0, 1'b0, 16'd6, 9'h046);
    step(1'b1, 1'b0, 1'b0, 16'd7, HALT_OP);
    chk("halt_stall", 32'(Stall), 1);
    chk("halt_count", 32'(Count), 2);
    step(1'b1, 1'b0, 1'b0, 16'd9, 9'h049);
    chk("halt_refuse", 32'(Count), 2);
    step(1'b0, 1'b1, 1'b0, 16'd0, 9'h000);
    chk("halt_head7", 32'(Out_pc), 7);
    step(1'b0, 1'b1, 1'b0, 16'd0, 9'h000);
    chk("halt_drained", 32'(Count), 0);
    chk("halt_stall_empty", 32'(Stall), 1);
    step(1'b0, 1'b1, 1'b0, 16'd0, 9'h000);
    chk("empty_deq", 32'(Count), 0);
    step(1'b0, 1'b0, 1'b1, 16'd0, 9'h000);
    chk("flush_unhalt", 32'(Stall), 0);

    // Sustained fill+deq across pointer wrap.
    step(1'b1, 1'b0, 1'b0, 16'd100, 9'h064);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'(100 + i), 9'(i));
      chk("wrap_pc", 32'(Out_pc), 100 + i);
      chk("wrap_count", 32'(Count), 1);
    end

    // Asynchronous Init mid-cycle with three entries queued.
    step(1'b1, 1'b0, 1'b0, 16'd200, 9'h0C8);
    step(1'b1, 1'b0, 1'b0, 16'd201, 9'h0C9);
    chk("pre_init_count", 32'(Count), 3);
    #2 Init = 1'b1;
    #1;
    chk("ainit_valid", 32'(Out_valid), 0);
    chk("ainit_count", 32'(Count), 0);
    chk("ainit_stall", 32'(Stall), 0);
    chk("ainit_pc", 32'(Out_pc), 0);
    sb.delete();
    m_halt = 1'b0;
    #1 Init = 1'b0;
    @(posedge CLK);
    #1;
    step(1'b1, 1'b0, 1'b0, 16'd300, 9'h012);
    chk("post_init_fill", 32'(Count), 1);
    chk("post_init_head", 32'(Out_pc), 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
